video_pattern_gen: RTL

VIDEO_PATTERN_GEN -- requirements
Module: video_pattern_gen

---
 rtl/video_pattern_gen.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/video_pattern_gen.sv
// Video timing and test-pattern generator: counters, IDLE/RUN control, registered outputs.
// Optional macro PATTERN_SCROLL_EN turns the gradient offset into a per-frame scrolling register.
module video_pattern_gen #(
    parameter int unsigned H_ACTIVE = 64,
    parameter int unsigned H_FP     = 4,
    parameter int unsigned H_SYNC   = 8,
    parameter int unsigned H_BP     = 4,
    parameter int unsigned V_ACTIVE = 48,
    parameter int unsigned V_FP     = 2,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BP     = 2,
    parameter bit          SYNC_POL = 1'b1
) (
    input  logic       hdmi_clk,
    input  logic       hdmi_rst_n,
    input  logic       enable,
    input  logic [1:0] pattern_sel,
    output logic       hdmi_de,
    output logic       hdmi_hs,
    output logic       hdmi_vs,
    output logic [7:0] hdmi_r,
    output logic [7:0] hdmi_g,
    output logic [7:0] hdmi_b,
    output logic       frame_start
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    // At least 4 bits so the checkerboard can always use bit 3 of each counter.
    localparam int unsigned HW = ($clog2(H_TOTAL + 1) < 4) ? 4 : $clog2(H_TOTAL + 1);
    localparam int unsigned VW = ($clog2(V_TOTAL + 1) < 4) ? 4 : $clog2(V_TOTAL + 1);

    localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_ACT_L  = HW'(H_ACTIVE);
    localparam logic [HW-1:0] HS_START = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] HS_END   = HW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [HW-1:0] BAR_W    = HW'(H_ACTIVE / 8);
    localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_ACT_L  = VW'(V_ACTIVE);
    localparam logic [VW-1:0] VS_START = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] VS_END   = VW'(V_ACTIVE + V_FP + V_SYNC);

    typedef enum logic {StIdle, StRun} state_e;

    state_e        state_q, state_d;
    logic [HW-1:0] h_cnt_q, h_cnt_d;
    logic [VW-1:0] v_cnt_q, v_cnt_d;
    logic [1:0]    pat_q, pat_d;
    logic [7:0]    offset;

    logic          running;
    logic          frame_first;
    logic          frame_end;
    logic [1:0]    pat_cur;

    logic          de_d, hs_d, vs_d, fs_d;
    logic [23:0]   rgb_d;
    logic          de_q, hs_q, vs_q, fs_q;
    logic [23:0]   rgb_q;

    assign running     = (state_q == StRun);
    assign frame_first = (h_cnt_q == '0) && (v_cnt_q == '0);
    assign frame_end   = running && (h_cnt_q == H_LAST) && (v_cnt_q == V_LAST);
    // The pixel at (0,0) already uses the pattern being latched on that cycle.
    assign pat_cur     = frame_first ? pattern_sel : pat_q;

    // State register
    always_ff @(posedge hdmi_clk or negedge hdmi_rst_n) begin
        if (!hdmi_rst_n) begin
            state_q <= StIdle;
            h_cnt_q <= '0;
            v_cnt_q <= '0;
            pat_q   <= 2'd0;
        end else begin
            state_q <= state_d;
            h_cnt_q <= h_cnt_d;
            v_cnt_q <= v_cnt_d;
            pat_q   <= pat_d;
        end
    end

    // Next-state logic; enable only matters when idle or at the last pixel of a frame.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: if (enable) state_d = StRun;
            StRun:  if (frame_end && !enable) state_d = StIdle;
        endcase
    end

    always_comb begin
        h_cnt_d = '0;
        v_cnt_d = '0;
        pat_d   = pat_q;
        if (running) begin
            if (frame_first) pat_d = pattern_sel;
            if (h_cnt_q == H_LAST) begin
                h_cnt_d = '0;
                v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + 1'b1;
            end else begin
                h_cnt_d = h_cnt_q + 1'b1;
                v_cnt_d = v_cnt_q;
            end
        end
    end

`ifdef PATTERN_SCROLL_EN
    logic [7:0] offset_q, offset_d;

    always_comb begin
        offset_d = offset_q;
        if (frame_end) offset_d = offset_q + 8'd1;
    end

    always_ff @(posedge hdmi_clk or negedge hdmi_rst_n) begin
        if (!hdmi_rst_n) offset_q <= 8'd0;
        else             offset_q <= offset_d;
    end

    assign offset = offset_q;
`else
    assign offset = 8'd0;
`endif

    // Output logic: next values for the output registers
    always_comb begin
        logic [2:0] bar;
        logic [7:0] grad;
        bar   = 3'(h_cnt_q / BAR_W);
        grad  = 8'(h_cnt_q) + offset;
        de_d  = running && (h_cnt_q < H_ACT_L) && (v_cnt_q < V_ACT_L);
        hs_d  = (running && (h_cnt_q >= HS_START) && (h_cnt_q < HS_END)) ? SYNC_POL : !SYNC_POL;
        vs_d  = (running && (v_cnt_q >= VS_START) && (v_cnt_q < VS_END)) ? SYNC_POL : !SYNC_POL;
        fs_d  = running && frame_first;
        rgb_d = 24'h000000;
        if (de_d) begin
            unique case (pat_cur)
                2'd0: begin
                    unique case (bar)
                        3'd0: rgb_d = 24'hFFFFFF;
                        3'd1: rgb_d = 24'hFFFF00;
                        3'd2: rgb_d = 24'h00FFFF;
                        3'd3: rgb_d = 24'h00FF00;
                        3'd4: rgb_d = 24'hFF00FF;
                        3'd5: rgb_d = 24'hFF0000;
                        3'd6: rgb_d = 24'h0000FF;
                        3'd7: rgb_d = 24'h000000;
                    endcase
                end
                2'd1: rgb_d = {grad, grad, grad};
                2'd2: rgb_d = (h_cnt_q[3] ^ v_cnt_q[3]) ? 24'hFFFFFF : 24'h000000;
                2'd3: rgb_d = 24'hFF0000;
            endcase
        end
    end

    always_ff @(posedge hdmi_clk or negedge hdmi_rst_n) begin
        if (!hdmi_rst_n) begin
            de_q  <= 1'b0;
            hs_q  <= !SYNC_POL;
            vs_q  <= !SYNC_POL;
            fs_q  <= 1'b0;
            rgb_q <= 24'h000000;
        end else begin
            de_q  <= de_d;
            hs_q  <= hs_d;
            vs_q  <= vs_d;
            fs_q  <= fs_d;
            rgb_q <= rgb_d;
        end
    end

    assign hdmi_de     = de_q;
    assign hdmi_hs     = hs_q;
    assign hdmi_vs     = vs_q;
    assign frame_start = fs_q;
    assign hdmi_r      = rgb_q[23:16];
    assign hdmi_g      = rgb_q[15:8];
    assign hdmi_b      = rgb_q[7:0];

endmodule
